// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed multi-digit 7-segment display driver. A DIGITS-wide nibble
// vector is captured into a pending register and copied into the display
// register only when the scan wraps from the last digit back to digit 0. This
// ensures a scan frame never mixes old and new digits. Each digit stays
// selected for PRESCALE clock cycles. The selected nibble is decoded as BCD
// (10..15 dark) or as hex glyphs A b C d E F.
//
// Parameters
//   DIGITS    number of digits, 1..8
//   PRESCALE  clock cycles each digit stays selected, >= 1
//   HEX_MODE  0: nibbles 10..15 blank, 1: nibbles 10..15 show A b C d E F
//
// Ports
//   clk       in   1         rising-edge clock
//   reset_n   in   1         asynchronous active-low reset
//   value     in   4*DIGITS  nibble i at [4i+3:4i], digit 0 rightmost
//   load      in   1         capture value into the pending register
//   lt        in   1         lamp test: all segments on for the selected digit
//   blank     in   1         all digit selects and segments off (beats lt)
//   rbi       in   1         enable leading-zero blanking
//   seg       out  7         {a,b,c,d,e,f,g}, active-high, registered
//   digit_en  out  DIGITS    one-hot active-high digit select, registered
//   frame     out  1         one-cycle pulse: digit 0 of a new frame selected
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int HEX_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  lt,
    input  logic                  blank,
    input  logic                  rbi,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Segment patterns, bit 6 = a ... bit 0 = g.
    localparam logic [6:0] SEG_OFF = 7'b0000000;
    localparam logic [6:0] SEG_ALL = 7'b1111111;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [4*DIGITS-1:0] r_pending;
    logic [4*DIGITS-1:0] r_disp;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_digit_en;
    logic                r_frame;

    // -----------------------------------------------------------------------
    // Next-state signals
    // -----------------------------------------------------------------------
    logic                w_tick;
    logic                w_wrap;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [4*DIGITS-1:0] w_pending_nxt;
    logic [4*DIGITS-1:0] w_disp_nxt;
    logic [DIGITS-1:0]   w_lz;
    logic [3:0]          w_sel_nib;
    logic                w_sel_lz;
    logic [DIGITS-1:0]   w_onehot;
    logic [6:0]          w_seg_nxt;
    logic [DIGITS-1:0]   w_digit_en_nxt;

    // -----------------------------------------------------------------------
    // Nibble to segment decode
    // -----------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = (HEX_MODE != 0) ? 7'b1110111 : SEG_OFF;
            4'hB:    s = (HEX_MODE != 0) ? 7'b0011111 : SEG_OFF;
            4'hC:    s = (HEX_MODE != 0) ? 7'b1001110 : SEG_OFF;
            4'hD:    s = (HEX_MODE != 0) ? 7'b0111101 : SEG_OFF;
            4'hE:    s = (HEX_MODE != 0) ? 7'b1001111 : SEG_OFF;
            default: s = (HEX_MODE != 0) ? 7'b1000111 : SEG_OFF;
        endcase
        return s;
    endfunction

    // -----------------------------------------------------------------------
    // Prescaler and scan index
    // -----------------------------------------------------------------------
    assign w_tick = (r_cnt == CNT_W'(PRESCALE - 1));
    assign w_wrap = w_tick && (r_idx == IDX_W'(DIGITS - 1));

    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_idx_nxt = r_idx;
        if (w_tick) begin
            w_cnt_nxt = '0;
            w_idx_nxt = w_wrap ? '0 : r_idx + IDX_W'(1);
        end
    end

    // A load on the wrap edge bypasses pending straight into disp. This way
    // the newest value is never held back a whole frame.
    assign w_pending_nxt = load ? value : r_pending;
    assign w_disp_nxt    = w_wrap ? (load ? value : r_pending) : r_disp;

    // -----------------------------------------------------------------------
    // Leading-zero mask: bit k set when nibbles DIGITS-1..k are all zero.
    // Digit 0 always shows, so that an all-zero value still displays "0".
    // -----------------------------------------------------------------------
    always_comb begin
        logic l_run;
        l_run = 1'b1;
        w_lz  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            l_run = l_run & (w_disp_nxt[4*k +: 4] == 4'h0);
            if (k != 0) begin
                w_lz[k] = l_run;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output selection from the next-state index and display register, so
    // seg/digit_en move on the same edge as idx. Priority: blank, lt,
    // leading-zero blanking, then decode.
    // -----------------------------------------------------------------------
    always_comb begin
        w_sel_nib = 4'h0;
        w_sel_lz  = 1'b0;
        w_onehot  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_idx_nxt == IDX_W'(k)) begin
                w_sel_nib   = w_disp_nxt[4*k +: 4];
                w_sel_lz    = w_lz[k];
                w_onehot[k] = 1'b1;
            end
        end

        w_seg_nxt      = decode(w_sel_nib);
        w_digit_en_nxt = w_onehot;
        if (blank) begin
            w_seg_nxt      = SEG_OFF;
            w_digit_en_nxt = '0;
        end else if (lt) begin
            w_seg_nxt = SEG_ALL;
        end else if (rbi && w_sel_lz) begin
            // The digit select stays driven and only the segments go dark.
            w_seg_nxt = SEG_OFF;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers therefore update together from values sampled before the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_disp     <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_seg      <= SEG_OFF;
            r_digit_en <= '0;
            r_frame    <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_disp     <= w_disp_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_seg      <= w_seg_nxt;
            r_digit_en <= w_digit_en_nxt;
            r_frame    <= w_wrap;
        end
    end

    assign seg      = r_seg;
    assign digit_en = r_digit_en;
    assign frame    = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver. It uses three instances that share
// stimulus: a 4-digit BCD driver, a 4-digit hex driver (both PRESCALE=4) and
// a 1-digit driver with PRESCALE=3. Edge numbers in comments count rising
// edges since the latest reset release. Outputs are sampled 1 ns after an edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        lt = 1'b0;
    logic        blank = 1'b0;
    logic        rbi = 1'b0;

    logic [6:0]  seg_bcd, seg_hex, seg_one;
    logic [3:0]  en_bcd, en_hex;
    logic [0:0]  en_one;
    logic        frame_bcd, frame_hex, frame_one;

    int n_checks = 0;
    int n_fails  = 0;
    int e        = 0;   // rising edges since reset release

    localparam logic [6:0] S0   = 7'b1111110;
    localparam logic [6:0] S1   = 7'b0110000;
    localparam logic [6:0] S2   = 7'b1101101;
    localparam logic [6:0] S3   = 7'b1111001;
    localparam logic [6:0] S4   = 7'b0110011;
    localparam logic [6:0] S5   = 7'b1011011;
    localparam logic [6:0] S9   = 7'b1111011;
    localparam logic [6:0] SA   = 7'b1110111;
    localparam logic [6:0] SOFF = 7'b0000000;
    localparam logic [6:0] SALL = 7'b1111111;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .HEX_MODE(0)) u_bcd (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load), .lt(lt),
        .blank(blank), .rbi(rbi), .seg(seg_bcd), .digit_en(en_bcd), .frame(frame_bcd)
    );

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .HEX_MODE(1)) u_hex (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load), .lt(lt),
        .blank(blank), .rbi(rbi), .seg(seg_hex), .digit_en(en_hex), .frame(frame_hex)
    );

    seg7_scan_driver #(.DIGITS(1), .PRESCALE(3), .HEX_MODE(0)) u_one (
        .clk(clk), .reset_n(reset_n), .value(value[3:0]), .load(load), .lt(lt),
        .blank(blank), .rbi(rbi), .seg(seg_one), .digit_en(en_one), .frame(frame_one)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the given edge count; sample point is 1 ns after the edge.
    task automatic tick_to(input int target);
        while (e < target) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    // Drive a one-edge load pulse captured by the next rising edge.
    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick_to(e + 1);
        load  = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        #2 reset_n = 1'b0;
        #1;
        check("rst_seg",   32'(seg_bcd),   32'(SOFF));
        check("rst_en",    32'(en_bcd),    32'h0);
        check("rst_frame", 32'(frame_bcd), 32'h0);
        check("rst_en_one", 32'(en_one),   32'h0);
        #19 reset_n = 1'b1;   // released at t=22, between edges
        e = 0;

        // ---------------- scan sequence ----------------
        tick_to(1);
        check("e1_en",    32'(en_bcd),    32'h1);
        check("e1_seg",   32'(seg_bcd),   32'(S0));
        check("e1_frame", 32'(frame_bcd), 32'h0);
        check("e1_hex_seg", 32'(seg_hex), 32'(S0));
        check("one_e1_en", 32'(en_one),   32'h1);
        check("one_e1_seg", 32'(seg_one), 32'(S0));
        tick_to(3);
        check("e3_en",     32'(en_bcd),    32'h1);
        check("one_e3_frame", 32'(frame_one), 32'h1);
        tick_to(4);
        check("e4_en",     32'(en_bcd),    32'h2);
        check("e4_seg",    32'(seg_bcd),   32'(S0));
        check("one_e4_frame", 32'(frame_one), 32'h0);
        tick_to(6);
        check("one_e6_frame", 32'(frame_one), 32'h1);
        check("one_e6_en",    32'(en_one),    32'h1);
        tick_to(8);
        check("e8_en",     32'(en_bcd),    32'h4);
        tick_to(12);
        check("e12_en",    32'(en_bcd),    32'h8);
        tick_to(15);
        check("e15_en",    32'(en_bcd),    32'h8);
        check("e15_frame", 32'(frame_bcd), 32'h0);
        tick_to(16);
        check("e16_en",    32'(en_bcd),    32'h1);
        check("e16_frame", 32'(frame_bcd), 32'h1);
        tick_to(17);
        check("e17_frame", 32'(frame_bcd), 32'h0);
        tick_to(32);
        check("e32_frame", 32'(frame_bcd), 32'h1);

        // ---------------- mid-frame load 1234 ----------------
        pulse_load(16'h1234);                 // captured at edge 33
        tick_to(36);
        check("old_frame_d1", 32'(seg_bcd),   32'(S0));
        tick_to(48);
        check("e48_frame", 32'(frame_bcd), 32'h1);
        check("d0_is_4",   32'(seg_bcd),   32'(S4));
        tick_to(52);
        check("d1_is_3",   32'(seg_bcd),   32'(S3));
        tick_to(56);
        check("d2_is_2",   32'(seg_bcd),   32'(S2));
        tick_to(60);
        check("d3_is_1",   32'(seg_bcd),   32'(S1));
        check("d3_en",     32'(en_bcd),    32'h8);

        // ---------------- 00A5 with rbi ----------------
        tick_to(61);
        rbi = 1'b1;
        pulse_load(16'h00A5);                 // edge 62
        tick_to(64);
        check("a5_d0_bcd", 32'(seg_bcd), 32'(S5));
        check("a5_d0_hex", 32'(seg_hex), 32'(S5));
        tick_to(68);
        check("a5_d1_bcd", 32'(seg_bcd), 32'(SOFF));
        check("a5_d1_hex", 32'(seg_hex), 32'(SA));
        tick_to(72);
        check("a5_d2_bcd", 32'(seg_bcd), 32'(SOFF));
        check("a5_d2_hex", 32'(seg_hex), 32'(SOFF));
        check("a5_d2_en",  32'(en_bcd),  32'h4);
        tick_to(76);
        check("a5_d3_hex", 32'(seg_hex), 32'(SOFF));

        // ---------------- 0000 then 0100 with rbi ----------------
        tick_to(77);
        pulse_load(16'h0000);                 // edge 78
        tick_to(80);
        check("z_d0", 32'(seg_bcd), 32'(S0));
        tick_to(84);
        check("z_d1", 32'(seg_bcd), 32'(SOFF));
        check("z_d1_en", 32'(en_bcd), 32'h2);
        tick_to(92);
        check("z_d3", 32'(seg_bcd), 32'(SOFF));
        tick_to(93);
        pulse_load(16'h0100);                 // edge 94
        tick_to(96);
        check("h100_d0", 32'(seg_bcd), 32'(S0));
        tick_to(100);
        check("h100_d1", 32'(seg_bcd), 32'(S0));
        tick_to(104);
        check("h100_d2", 32'(seg_bcd), 32'(S1));
        tick_to(108);
        check("h100_d3", 32'(seg_bcd), 32'(SOFF));
        check("h100_d3_en", 32'(en_bcd), 32'h8);

        // ---------------- lamp test and blank ----------------
        tick_to(109);
        lt = 1'b1;
        tick_to(110);
        check("lt_seg_d3", 32'(seg_bcd), 32'(SALL));
        check("lt_en_d3",  32'(en_bcd),  32'h8);
        tick_to(112);
        check("lt_seg_d0", 32'(seg_bcd), 32'(SALL));
        check("lt_en_d0",  32'(en_bcd),  32'h1);
        blank = 1'b1;
        tick_to(113);
        check("blank_en",  32'(en_bcd),  32'h0);
        check("blank_seg", 32'(seg_bcd), 32'(SOFF));
        check("blank_en_one", 32'(en_one), 32'h0);
        lt    = 1'b0;
        blank = 1'b0;
        tick_to(114);
        check("unblank_en",  32'(en_bcd),  32'h1);
        check("unblank_seg", 32'(seg_bcd), 32'(S0));

        // ---------------- load exactly on the wrap edge ----------------
        tick_to(127);
        pulse_load(16'h9999);                 // edge 128 is a wrap edge
        check("wrap_frame", 32'(frame_bcd), 32'h1);
        check("wrap_d0_9",  32'(seg_bcd),   32'(S9));
        tick_to(132);
        check("wrap_d1_9",  32'(seg_bcd),   32'(S9));
        tick_to(140);
        check("wrap_d3_9",  32'(seg_bcd),   32'(S9));
        check("wrap_d3_en", 32'(en_bcd),    32'h8);

        // ---------------- reset mid-frame ----------------
        tick_to(142);
        rbi = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_seg",   32'(seg_bcd),   32'(SOFF));
        check("mid_rst_en",    32'(en_bcd),    32'h0);
        check("mid_rst_frame", 32'(frame_bcd), 32'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        e = 0;
        tick_to(1);
        check("post_rst_en",  32'(en_bcd),  32'h1);
        check("post_rst_seg", 32'(seg_bcd), 32'(S0));
        tick_to(12);
        check("post_rst_d3",  32'(seg_bcd), 32'(S0));
        tick_to(16);
        check("post_rst_frame", 32'(frame_bcd), 32'h1);
        check("post_rst_d0",    32'(seg_bcd),   32'(S0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Safety net: the directed sequence is short, so this never fires normally.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
